// File: rtl/regfile_sb_pkg.sv
// Core-wide register file constants shared by decode, issue and write-back.
package regfile_sb_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: tracks outstanding producers, rejects WAW issues
// and keeps a registered count of busy registers.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int SB_NREG = NREG,
  parameter int SB_AW   = AW
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [SB_AW-1:0] rs1_addr,
  input  logic [SB_AW-1:0] rs2_addr,
  input  logic             issue_en,
  input  logic [SB_AW-1:0] issue_rd,
  input  logic             wb_en,
  input  logic [SB_AW-1:0] wb_rd,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             issue_stall,
  output logic [SB_AW:0]   pending_cnt
);

  localparam logic [SB_AW:0] CNT_ONE = {{SB_AW{1'b0}}, 1'b1};

  logic [SB_NREG-1:0] busy_q, busy_d;
  logic [SB_AW:0]     pending_cnt_q, pending_cnt_d;
  logic               wb_live;
  logic               issue_ok;

  // A write-back in the same cycle retires the old producer, so it masks busy.
  always_comb begin
    wb_live     = wb_en && (wb_rd != ZERO_REG);
    issue_stall = issue_en && (issue_rd != ZERO_REG) && busy_q[issue_rd] &&
                  !(wb_en && (wb_rd == issue_rd));
    issue_ok    = issue_en && !issue_stall && (issue_rd != ZERO_REG);
    rs1_busy    = busy_q[rs1_addr] && !(wb_en && (wb_rd == rs1_addr));
    rs2_busy    = busy_q[rs2_addr] && !(wb_en && (wb_rd == rs2_addr));

    busy_d        = busy_q;
    pending_cnt_d = pending_cnt_q;
    if (wb_live) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (issue_ok) begin
      busy_d[issue_rd] = 1'b1;
    end
    // Count changes only on real 0->1 / 1->0 transitions of a busy bit.
    if (issue_ok && !busy_q[issue_rd]) begin
      pending_cnt_d = pending_cnt_d + CNT_ONE;
    end
    if (wb_live && busy_q[wb_rd] && !(issue_ok && (issue_rd == wb_rd))) begin
      pending_cnt_d = pending_cnt_d - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      busy_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  assign pending_cnt = pending_cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Architectural register file with write-through bypass on both read ports,
// wrapped around the busy scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int RF_XLEN = XLEN,
  parameter int RF_NREG = NREG,
  parameter int RF_AW   = AW
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic [RF_AW-1:0]   rs1_addr,
  input  logic [RF_AW-1:0]   rs2_addr,
  output logic [RF_XLEN-1:0] rs1_data,
  output logic [RF_XLEN-1:0] rs2_data,
  output logic               rs1_busy,
  output logic               rs2_busy,
  input  logic               issue_en,
  input  logic [RF_AW-1:0]   issue_rd,
  output logic               issue_stall,
  input  logic               wb_en,
  input  logic [RF_AW-1:0]   wb_rd,
  input  logic [RF_XLEN-1:0] wb_data,
  output logic [RF_AW:0]     pending_cnt
);

  logic [RF_XLEN-1:0] regs_q [RF_NREG];
  logic [RF_XLEN-1:0] regs_d [RF_NREG];

  always_comb begin
    regs_d = regs_q;
    if (wb_en && (wb_rd != ZERO_REG)) begin
      regs_d[wb_rd] = wb_data;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < RF_NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Register 0 reads as zero even if a write-back targets it this cycle.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != ZERO_REG) begin
      rs1_data = (wb_en && (wb_rd == rs1_addr)) ? wb_data : regs_q[rs1_addr];
    end
    if (rs2_addr != ZERO_REG) begin
      rs2_data = (wb_en && (wb_rd == rs2_addr)) ? wb_data : regs_q[rs2_addr];
    end
  end

  regfile_scoreboard #(
    .SB_NREG(RF_NREG),
    .SB_AW  (RF_AW)
  ) u_scoreboard (
    .clk        (clk),
    .res_n      (res_n),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .issue_stall(issue_stall),
    .pending_cnt(pending_cnt)
  );

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Architectural register file for the core, plus a per-register busy scoreboard.
- Write side accepts the write-back result; the read side serves two operand ports to decode/issue.
- Write-through bypass lets a same-cycle write-back be read immediately.
- The scoreboard tracks registers with an outstanding producer and blocks WAW issues.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (register 0 hardwired to zero)
AW, 5, register address width, equals log2(NREG)

Ports:
clk  input  1  system clock, rising edge
res_n  input  1  asynchronous active-low reset
rs1_addr  input  AW  read port 1 address
rs2_addr  input  AW  read port 2 address
rs1_data  output  XLEN  read port 1 data (combinational)
rs2_data  output  XLEN  read port 2 data (combinational)
rs1_busy  output  1  rs1 has an outstanding producer and no same-cycle write-back
rs2_busy  output  1  same for rs2
issue_en  input  1  instruction issuing this cycle with destination issue_rd
issue_rd  input  AW  destination of the issuing instruction
issue_stall  output  1  issue rejected this cycle (WAW on busy rd)
wb_en  input  1  write-back valid
wb_rd  input  AW  write-back destination
wb_data  input  XLEN  write-back data
pending_cnt  output  AW+1  number of registers currently marked busy

Behaviour:
- Reset (res_n low, asynchronous): all registers 0, all busy bits 0, pending_cnt 0. Combinational outputs follow: rsX_data 0, rsX_busy 0, issue_stall 0.
- Reset asserted mid-operation clears everything immediately, regardless of clk.
- Write: on rising clk with wb_en=1 and wb_rd!=0, reg[wb_rd] <= wb_data. Writes to register 0 are ignored.
- Read: rsX_data = 0 if rsX_addr==0.
- Else rsX_data = wb_data if wb_en && wb_rd==rsX_addr (bypass, zero latency).
- Else rsX_data = reg[rsX_addr].
- rsX_busy = busy[rsX_addr] && !(wb_en && wb_rd==rsX_addr). Always 0 for address 0.
- issue_stall = issue_en && issue_rd!=0 && busy[issue_rd] && !(wb_en && wb_rd==issue_rd).
- Busy update per clk edge, per register r!=0:
  - set if issue_en && !issue_stall && issue_rd==r;
  - else clear if wb_en && wb_rd==r;
  - else hold.
- Issue and write-back to the same r in the same cycle: write-back data is stored and busy ends set, because the new producer wins.
- Write-back to a non-busy register: data written, busy stays 0, no error.
- Issue with issue_rd==0: accepted, no busy change, never stalls.
- pending_cnt is registered and equals the popcount of busy bits after each edge.
  - Updated incrementally: +1 on accepted set, −1 on clear, net 0 when both hit the same register.
  - Maximum value NREG−1; no wrap possible.
- Both read ports may address the same register; both return identical data and busy.

Decomposition:
- Shared core package holds XLEN, NREG, AW and the ZERO_REG index constant, so decode and write-back stages use the same values.
- Natural sub-module: regfile_scoreboard. It contains the busy vector, stall logic and pending_cnt, separate from the data array and bypass muxes in regfile_sb.

Test Plan:
- Reset: hold res_n=0, then release after 13 time units → every rsX_data reads 0 for addresses 0..31, pending_cnt=0, no busy.
- Write/read: wb_en=1, wb_rd=5, wb_data=100 for one edge; rs1_addr=5 → rs1_data=100. Then wb_data=200 with rs2_addr=5 in the same cycle → rs2_data=200 before the edge (bypass) and 200 after.
- Register 0: wb_rd=0, wb_data=300 → rs1_addr=0 returns 0. issue_rd=0 → issue_stall=0, pending_cnt unchanged.
- Scoreboard:
  - issue_rd=7 → after the edge rs1_busy(7)=1 and pending_cnt=1.
  - A second issue_rd=7 → issue_stall=1 and pending_cnt stays 1.
  - wb_rd=7, wb_data=42 → rs1_busy=0 in the same cycle, rs1_data=42, pending_cnt=0 after the edge.
- Simultaneous: reg 9 busy; in one cycle issue_rd=9 and wb_rd=9 with wb_data=55 → issue_stall=0, reg9=55, busy[9] stays 1, pending_cnt unchanged.
- Async reset mid-operation: with regs 3 and 4 busy, pull res_n low between edges → pending_cnt=0 and rs1_data=0 immediately, without waiting for clk.
